// File: rtl/pb_pkg.sv
// pb_pkg: shared defaults, button indices and scale table for the mode selector
package pb_pkg;
  localparam int DEF_NUM_PB       = 2;
  localparam int DEF_DB_CYCLES    = 16;
  localparam int DEF_NUM_SETTINGS = 4;
  localparam int DEF_RST_SETTING  = 2;
  localparam int DEF_LONG_CYCLES  = 1024;
  localparam int UP_IDX           = 0;
  localparam int DN_IDX           = 1;
  localparam logic [2:0] SCALE_LUT [8] = '{3'd0, 3'd3, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: one button channel - 2-flop synchronizer, stability counter, level and press pulse
module pb_debounce
  import pb_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d, pulse_q, pulse_d, diff, done;
  // count consecutive mismatches; toggle the level once the window is full
  always_comb begin
    diff    = sync_q[1] ^ level_q;
    done    = diff && (cnt_q == LAST);
    cnt_d   = (diff && !done) ? cnt_q + 1'b1 : '0;
    level_d = level_q ^ done;
    pulse_d = done && !level_q;
  end
  // synchronizer and debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end
  assign level_o = level_q;
  assign pulse_o = pulse_q;
endmodule

// File: rtl/pb_mode_sel.sv
// pb_mode_sel: debounced push buttons stepping a mode setting, with long-press return to the reset setting
module pb_mode_sel
  import pb_pkg::*;
#(
  parameter int NUM_PB       = DEF_NUM_PB,
  parameter int DB_CYCLES    = DEF_DB_CYCLES,
  parameter int NUM_SETTINGS = DEF_NUM_SETTINGS,
  parameter int RST_SETTING  = DEF_RST_SETTING,
  parameter int LONG_CYCLES  = DEF_LONG_CYCLES,
  localparam int SW          = (NUM_SETTINGS > 2) ? $clog2(NUM_SETTINGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_pulse,
  output logic              long_press,
  output logic [SW-1:0]     setting,
  output logic [2:0]        scale
);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_CYCLES);
  localparam logic [SW-1:0] SET_MAX  = SW'(NUM_SETTINGS - 1);
  localparam logic [SW-1:0] SET_RST  = SW'(RST_SETTING);
  logic          up, dn, hit, long_q;
  logic [LW-1:0] hold_q, hold_d;
  logic [SW-1:0] setting_q, setting_d;
  genvar i;
  for (i = 0; i < NUM_PB; i++) begin : g_ch
    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (pb_raw[i]),
      .level_o (pb_level[i]),
      .pulse_o (pb_pulse[i])
    );
  end
  if (NUM_PB >= 2) begin : g_dn
    assign dn = pb_pulse[DN_IDX];
  end else begin : g_no_dn
    assign dn = 1'b0;
  end
  assign up = pb_pulse[UP_IDX];
  // hold counter saturates; its first arrival at the limit overrides any button step
  always_comb begin
    hit       = pb_level[UP_IDX] && (hold_q == HOLD_MAX - 1'b1);
    hold_d    = !pb_level[UP_IDX] ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
    setting_d = hit ? SET_RST :
                (up && !dn) ? ((setting_q == SET_MAX) ? '0 : setting_q + 1'b1) :
                (dn && !up) ? ((setting_q == '0) ? SET_MAX : setting_q - 1'b1) :
                setting_q;
  end
  // hold counter, long-press pulse and current setting registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      long_q    <= 1'b0;
      setting_q <= SET_RST;
    end else begin
      hold_q    <= hold_d;
      long_q    <= hit;
      setting_q <= setting_d;
    end
  end
  assign long_press = long_q;
  assign setting    = setting_q;
  assign scale      = SCALE_LUT[3'(setting_q)];
endmodule

// File: tb/tb_pb_mode_sel.sv
// tb_pb_mode_sel: vector table, timed corner sequences and random presses against a window-based reference model
module tb_pb_mode_sel;
  localparam int DB = 4, LONG = 20, RST_SET = 2;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] pb_raw, pb_level, pb_pulse, setting;
  logic       long_press;
  logic [2:0] scale;
  int         n_cmp = 0, n_bad = 0;
  int         scale_tab [4] = '{0, 3, 5, 7};

  always #5 clk = ~clk;

  pb_mode_sel #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pb_raw     (pb_raw),
    .pb_level   (pb_level),
    .pb_pulse   (pb_pulse),
    .long_press (long_press),
    .setting    (setting),
    .scale      (scale)
  );

  // model: a level flips when the last DB synchronized samples all disagree with it
  typedef struct {
    logic [1:0]       lvl, pulse;
    logic             lng;
    int               run, set;
    logic [1:0][15:0] h;
  } model_t;
  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.lvl = '0; r.pulse = '0; r.lng = 1'b0; r.run = 0; r.set = RST_SET; r.h = '0;
    return r;
  endfunction

  function automatic model_t step(model_t c, logic [1:0] raw);
    model_t n;
    logic   all_diff;
    n = c;
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = 1'b1;
      for (int k = 1; k <= DB; k++) if (c.h[ch][k] == c.lvl[ch]) all_diff = 1'b0;
      n.lvl[ch]   = c.lvl[ch] ^ all_diff;
      n.pulse[ch] = all_diff && !c.lvl[ch];
      n.h[ch]     = {c.h[ch][14:0], raw[ch]};
    end
    n.run = c.lvl[0] ? ((c.run < LONG + 1) ? c.run + 1 : c.run) : 0;
    n.lng = c.lvl[0] && (n.run == LONG);
    n.set = n.lng ? RST_SET :
            (c.pulse[0] && !c.pulse[1]) ? (c.set + 1) % 4 :
            (c.pulse[1] && !c.pulse[0]) ? (c.set + 3) % 4 : c.set;
    return n;
  endfunction

  // reference model advances on the same edges and reset as the design
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, pb_raw);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("m_level", 32'(pb_level), 32'(m.lvl));
    chk("m_pulse", 32'(pb_pulse), 32'(m.pulse));
    chk("m_long", 32'(long_press), 32'(m.lng));
    chk("m_setting", 32'(setting), m.set);
    chk("m_scale", 32'(scale), scale_tab[m.set]);
  endtask

  typedef struct {
    logic [1:0] raw;
    int         hold, set, scl, p0, p1, lng;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int p0, p1, ln, dur;
    tbl[0]  = '{2'b01,  8, 3, 7, 1, 0, 0};
    tbl[1]  = '{2'b01,  8, 0, 0, 1, 0, 0};
    tbl[2]  = '{2'b10,  8, 3, 7, 0, 1, 0};
    tbl[3]  = '{2'b11,  8, 3, 7, 1, 1, 0};
    tbl[4]  = '{2'b01,  3, 3, 7, 0, 0, 0};
    tbl[5]  = '{2'b10,  8, 2, 5, 0, 1, 0};
    tbl[6]  = '{2'b10,  8, 1, 3, 0, 1, 0};
    tbl[7]  = '{2'b01, 30, 2, 5, 1, 0, 1};
    tbl[8]  = '{2'b10,  2, 2, 5, 0, 0, 0};
    tbl[9]  = '{2'b10, 30, 1, 3, 0, 1, 0};
    tbl[10] = '{2'b01,  4, 2, 5, 1, 0, 0};
    rst_n  = 1'b0;
    pb_raw = 2'b00;
    repeat (2) cyc();
    chk("rst_setting", 32'(setting), 2);
    chk("rst_scale", 32'(scale), 5);
    chk("rst_level", 32'(pb_level), 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("idle_setting", 32'(setting), 2);
    chk("idle_scale", 32'(scale), 5);
    chk("idle_pulse", 32'(pb_pulse), 0);
    chk("idle_long", 32'(long_press), 0);
    // UP held from edge 0: pulse after edge 5, step at edge 6, long press at edge 25
    pb_raw = 2'b01;
    for (int e = 0; e <= 40; e++) begin
      cyc();
      chk("t_pulse", 32'(pb_pulse[0]), 32'(e == 5));
      chk("t_long", 32'(long_press), 32'(e == 25));
      chk("t_setting", 32'(setting), (e >= 6 && e < 25) ? 3 : 2);
    end
    pb_raw = 2'b00;
    repeat (15) cyc();
    chk("t_release_setting", 32'(setting), 2);
    // table of press records, each followed by a release gap
    foreach (tbl[v]) begin
      p0 = 0; p1 = 0; ln = 0;
      pb_raw = tbl[v].raw;
      for (int c = 0; c < tbl[v].hold + 15; c++) begin
        if (c == tbl[v].hold) pb_raw = 2'b00;
        cyc();
        p0 += int'(pb_pulse[0]);
        p1 += int'(pb_pulse[1]);
        ln += int'(long_press);
      end
      chk($sformatf("v%0d_setting", v), 32'(setting), tbl[v].set);
      chk($sformatf("v%0d_scale", v), 32'(scale), tbl[v].scl);
      chk($sformatf("v%0d_up_pulses", v), p0, tbl[v].p0);
      chk($sformatf("v%0d_dn_pulses", v), p1, tbl[v].p1);
      chk($sformatf("v%0d_longs", v), ln, tbl[v].lng);
    end
    // reset mid-hold, then button still held across release
    pb_raw = 2'b01;
    repeat (12) cyc();
    chk("hold_setting", 32'(setting), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(pb_level), 0);
    chk("arst_pulse", 32'(pb_pulse), 0);
    chk("arst_long", 32'(long_press), 0);
    chk("arst_setting", 32'(setting), 2);
    chk("arst_scale", 32'(scale), 5);
    repeat (2) cyc();
    rst_n = 1'b1;
    p0 = 0;
    repeat (12) begin cyc(); p0 += int'(pb_pulse[0]); end
    chk("held_rst_pulses", p0, 1);
    chk("held_rst_setting", 32'(setting), 3);
    pb_raw = 2'b00;
    repeat (15) cyc();
    // reset mid-debounce discards the partial count
    pb_raw = 2'b01;
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_db_level", 32'(pb_level), 0);
    chk("mid_db_setting", 32'(setting), 2);
    pb_raw = 2'b00;
    repeat (2) cyc();
    rst_n = 1'b1;
    p0 = 0;
    repeat (12) begin cyc(); p0 += int'(pb_pulse[0]); end
    chk("mid_db_pulses", p0, 0);
    chk("mid_db_setting2", 32'(setting), 2);
    // random presses, glitches and long holds
    for (int s = 0; s < 80; s++) begin
      pb_raw = 2'($urandom_range(0, 3));
      dur = ($urandom_range(0, 4) == 0) ? $urandom_range(22, 32) : $urandom_range(1, 7);
      repeat (dur) cyc();
      if ($urandom_range(0, 2) == 0) begin
        pb_raw = 2'b00;
        repeat ($urandom_range(1, 10)) cyc();
      end
    end
    pb_raw = 2'b00;
    repeat (20) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
